// File: rtl/alu_serial_arbiter_if.sv
// alu_serial_arbiter_if: request, response and ALU-side signals of the serial ALU arbiter
interface alu_serial_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_rs1;
  logic [31:0] req0_rs2;
  logic [2:0]  req0_func3;
  logic [6:0]  req0_func7;
  logic        req0_imm_t;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_rs1;
  logic [31:0] req1_rs2;
  logic [2:0]  req1_func3;
  logic [6:0]  req1_func7;
  logic        req1_imm_t;
  logic        resp0_valid;
  logic        resp0_ready;
  logic [31:0] resp0_rd;
  logic        resp0_err;
  logic        resp1_valid;
  logic        resp1_ready;
  logic [31:0] resp1_rd;
  logic        resp1_err;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;
  logic [2:0]  alu_func3;
  logic [6:0]  alu_func7;
  logic        alu_imm_t;
  logic        alu_start;
  logic        alu_done;
  logic [31:0] alu_rd;
  modport slave (
    input  req0_valid, req0_rs1, req0_rs2, req0_func3, req0_func7, req0_imm_t,
    input  req1_valid, req1_rs1, req1_rs2, req1_func3, req1_func7, req1_imm_t,
    input  resp0_ready, resp1_ready, alu_done, alu_rd,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_rd, resp0_err, resp1_valid, resp1_rd, resp1_err,
    output alu_rs1, alu_rs2, alu_func3, alu_func7, alu_imm_t, alu_start
  );
  modport master (
    output req0_valid, req0_rs1, req0_rs2, req0_func3, req0_func7, req0_imm_t,
    output req1_valid, req1_rs1, req1_rs2, req1_func3, req1_func7, req1_imm_t,
    output resp0_ready, resp1_ready, alu_done, alu_rd,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_rd, resp0_err, resp1_valid, resp1_rd, resp1_err,
    input  alu_rs1, alu_rs2, alu_func3, alu_func7, alu_imm_t, alu_start
  );
endinterface

// File: rtl/alu_serial_arbiter.sv
// alu_serial_arbiter: round-robin sharing of one bit-serial ALU between two requesters
module alu_serial_arbiter #(
  parameter int FLUSH_CYCLES   = 64,
  parameter int TIMEOUT_CYCLES = 80
) (
  input logic clk,
  input logic rst,
  alu_serial_arbiter_if.slave bus
);
  typedef enum logic [2:0] {FLUSH, IDLE, START, WAIT, RESP} state_t;
  state_t      state, state_n;
  logic [15:0] cnt;
  logic        rr_ptr, owner, gnt, req_any, hs, timeout, resp_hs, err_q, imm_q;
  logic [31:0] rs1_q, rs2_q, rd0_q, rd1_q;
  logic [2:0]  f3_q;
  logic [6:0]  f7_q;
  // grant, handshake and timeout decode
  always_comb begin
    req_any = bus.req0_valid | bus.req1_valid;
    gnt     = (bus.req0_valid & bus.req1_valid) ? rr_ptr : bus.req1_valid;
    hs      = (state == IDLE) & req_any;
    timeout = (state == WAIT) & ~bus.alu_done & (cnt == 16'(TIMEOUT_CYCLES - 1));
    resp_hs = (state == RESP) & (owner ? bus.resp1_ready : bus.resp0_ready);
  end
  // next-state logic; a timed-out operation drains the ALU again before new work
  always_comb begin
    state_n = state;
    case (state)
      FLUSH:   state_n = (bus.alu_done || cnt == 16'(FLUSH_CYCLES - 1)) ? IDLE : FLUSH;
      IDLE:    state_n = req_any ? START : IDLE;
      START:   state_n = WAIT;
      WAIT:    state_n = (bus.alu_done || timeout) ? RESP : WAIT;
      RESP:    state_n = resp_hs ? (err_q ? FLUSH : IDLE) : RESP;
      default: state_n = FLUSH;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= FLUSH;
    else state <= state_n;
  // shared flush/timeout counter: runs while FLUSH or WAIT persists, cleared otherwise
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= ((state == FLUSH || state == WAIT) && state_n == state) ? cnt + 16'd1 : '0;
  // operation latch and round-robin pointer update on acceptance
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rs1_q  <= '0;
      rs2_q  <= '0;
      f3_q   <= '0;
      f7_q   <= '0;
      imm_q  <= 1'b0;
      owner  <= 1'b0;
      rr_ptr <= 1'b0;
    end else if (hs) begin
      rs1_q  <= gnt ? bus.req1_rs1 : bus.req0_rs1;
      rs2_q  <= gnt ? bus.req1_rs2 : bus.req0_rs2;
      f3_q   <= gnt ? bus.req1_func3 : bus.req0_func3;
      f7_q   <= gnt ? bus.req1_func7 : bus.req0_func7;
      imm_q  <= gnt ? bus.req1_imm_t : bus.req0_imm_t;
      owner  <= gnt;
      rr_ptr <= ~gnt;
    end
  // result capture into the owner's response register; a timeout returns zero
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd0_q <= '0;
      rd1_q <= '0;
      err_q <= 1'b0;
    end else if (state == WAIT && (bus.alu_done || timeout)) begin
      err_q <= timeout;
      if (owner) rd1_q <= bus.alu_done ? bus.alu_rd : '0;
      else rd0_q <= bus.alu_done ? bus.alu_rd : '0;
    end
  assign bus.req0_ready  = hs & ~gnt;
  assign bus.req1_ready  = hs & gnt;
  assign bus.resp0_valid = (state == RESP) & ~owner;
  assign bus.resp1_valid = (state == RESP) & owner;
  assign bus.resp0_err   = bus.resp0_valid & err_q;
  assign bus.resp1_err   = bus.resp1_valid & err_q;
  assign bus.resp0_rd    = rd0_q;
  assign bus.resp1_rd    = rd1_q;
  assign bus.alu_rs1     = rs1_q;
  assign bus.alu_rs2     = rs2_q;
  assign bus.alu_func3   = f3_q;
  assign bus.alu_func7   = f7_q;
  assign bus.alu_imm_t   = imm_q;
  assign bus.alu_start   = (state == START);
endmodule

// File: tb/tb_alu_serial_arbiter.sv
// tb_alu_serial_arbiter: randomized and directed checks of the serial ALU arbiter
module tb_alu_serial_arbiter;
  localparam int FLUSH_CYCLES = 64, TIMEOUT_CYCLES = 80;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  alu_serial_arbiter_if bus();
  alu_serial_arbiter #(.FLUSH_CYCLES(FLUSH_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  typedef struct packed {logic [31:0] a; logic [31:0] b; logic [2:0] f3; logic [6:0] f7; logic imm;} op_t;
  typedef struct {bit v0; bit v1; int gnt; int exp;} gnt_t;
  int n_checks = 0, n_fail = 0;
  gnt_t glog[$];
  int rlog_own[$];
  logic [31:0] rlog_rd[$];
  op_t q0[$], q1[$];
  bit hang = 0, rand_lat = 0, busy = 0;
  int lat = 32, left = 0, n_start = 0, unstable = 0, r1_seen = 0, last = 1;
  op_t snap;

  function automatic logic [31:0] ref_alu(input op_t o);
    logic signed [31:0] s;
    logic [4:0] sh;
    s = o.a;
    sh = o.b[4:0];
    case (o.f3)
      3'd0: return (!o.imm && o.f7[5]) ? o.a - o.b : o.a + o.b;
      3'd1: return o.a << sh;
      3'd2: return {31'd0, $signed(o.a) < $signed(o.b)};
      3'd3: return {31'd0, o.a < o.b};
      3'd4: return o.a ^ o.b;
      3'd5: begin
        if (o.f7[5]) return s >>> sh;
        return o.a >> sh;
      end
      3'd6: return o.a | o.b;
      default: return o.a & o.b;
    endcase
  endfunction

  function automatic op_t alu_now();
    return {bus.alu_rs1, bus.alu_rs2, bus.alu_func3, bus.alu_func7, bus.alu_imm_t};
  endfunction

  function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3, input logic [6:0] f7);
    return {a, b, f3, f7, 1'b0};
  endfunction

  // serial ALU: reads its inputs live, has no reset, finishes 'left' cycles after start
  always @(negedge clk) begin
    bus.alu_done = 1'b0;
    if (bus.alu_start) begin
      busy = 1;
      left = rand_lat ? int'($urandom_range(30, 63)) : lat;
      snap = alu_now();
      n_start++;
    end else if (busy) begin
      if (alu_now() !== snap) unstable++;
      if (!hang) begin
        left--;
        if (left == 0) begin
          bus.alu_done = 1'b1;
          bus.alu_rd = ref_alu(alu_now());
          busy = 0;
        end
      end
    end
  end

  // grant scoreboard: round robin means "on contention, the one not served last"
  always @(negedge clk) begin
    int e, g;
    #2;
    if (bus.resp1_valid) r1_seen++;
    if (rst) last = 1;
    else if ((bus.req0_valid & bus.req0_ready) | (bus.req1_valid & bus.req1_ready)) begin
      e = (bus.req0_valid & bus.req1_valid) ? (last == 1 ? 0 : 1) : (bus.req1_valid ? 1 : 0);
      g = bus.req1_ready ? 1 : 0;
      glog.push_back('{bus.req0_valid, bus.req1_valid, g, e});
      last = g;
    end
  end

  task automatic wait_resp(input int n, input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
    end while (!(n != 0 ? bus.resp1_valid : bus.resp0_valid) && cyc < budget);
    if (!(n != 0 ? bus.resp1_valid : bus.resp0_valid)) cyc = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (FLUSH_CYCLES + 1) @(negedge clk);
  endtask

  task automatic run_ops(input bit rnd, input int budget);
    int total, done, cyc;
    bit p0, p1, hs0, hs1;
    logic [31:0] e0, e1;
    total = q0.size() + q1.size();
    done = 0; cyc = 0; p0 = 0; p1 = 0; hs0 = 0; hs1 = 0; e0 = '0; e1 = '0;
    while (done < total && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (hs0) bus.req0_valid = 1'b0;
      if (hs1) bus.req1_valid = 1'b0;
      if (!bus.req0_valid && q0.size() > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
        {bus.req0_rs1, bus.req0_rs2, bus.req0_func3, bus.req0_func7, bus.req0_imm_t} = q0[0];
        bus.req0_valid = 1'b1;
      end
      if (!bus.req1_valid && q1.size() > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
        {bus.req1_rs1, bus.req1_rs2, bus.req1_func3, bus.req1_func7, bus.req1_imm_t} = q1[0];
        bus.req1_valid = 1'b1;
      end
      bus.resp0_ready = !rnd || 1'($urandom_range(0, 1));
      bus.resp1_ready = !rnd || 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if ((bus.req0_ready & bus.req1_ready) | (bus.resp0_valid & bus.resp1_valid)) begin
        n_fail++;
        $display("FAIL one_hot: ready=%b%b resp_valid=%b%b, at most one of each required",
                 bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid);
      end
      hs0 = bus.req0_valid & bus.req0_ready;
      hs1 = bus.req1_valid & bus.req1_ready;
      if (hs0) begin e0 = ref_alu(q0.pop_front()); p0 = 1; end
      if (hs1) begin e1 = ref_alu(q1.pop_front()); p1 = 1; end
      if (bus.resp0_valid && bus.resp0_ready) begin
        n_checks++;
        if (!p0 || bus.resp0_rd !== e0 || bus.resp0_err !== 1'b0) begin
          n_fail++;
          $display("FAIL resp0: pending=%0d rd=%h err=%b, required rd=%h err=0", p0, bus.resp0_rd, bus.resp0_err, e0);
        end
        rlog_own.push_back(0); rlog_rd.push_back(bus.resp0_rd);
        p0 = 0; done++;
      end
      if (bus.resp1_valid && bus.resp1_ready) begin
        n_checks++;
        if (!p1 || bus.resp1_rd !== e1 || bus.resp1_err !== 1'b0) begin
          n_fail++;
          $display("FAIL resp1: pending=%0d rd=%h err=%b, required rd=%h err=0", p1, bus.resp1_rd, bus.resp1_err, e1);
        end
        rlog_own.push_back(1); rlog_rd.push_back(bus.resp1_rd);
        p1 = 0; done++;
      end
    end
    n_checks++;
    if (done != total) begin
      n_fail++;
      $display("FAIL run_ops_budget: %0d responses, required %0d", done, total);
    end
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
  endtask

  task automatic test_reset();
    int n, c;
    #1;
    n_checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid, bus.resp0_err, bus.resp1_err, bus.alu_start} !== 7'd0) begin
      n_fail++; $display("FAIL reset_ctrl: ctrl outputs not 0");
    end
    n_checks++;
    if (alu_now() !== '0) begin n_fail++; $display("FAIL reset_alu: alu regs=%h, required 0", alu_now()); end
    n_checks++;
    if ({bus.resp0_rd, bus.resp1_rd} !== 64'd0) begin n_fail++; $display("FAIL reset_rd: rd=%h/%h, required 0", bus.resp0_rd, bus.resp1_rd); end
    {bus.req0_rs1, bus.req0_rs2, bus.req0_func3, bus.req0_func7, bus.req0_imm_t} = mk(32'd1, 32'd1, 3'd0, 7'd0);
    bus.req0_valid = 1'b1; bus.resp0_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      #1;
      if (bus.req0_ready) break;
      n++;
    end
    n_checks++;
    if (n != FLUSH_CYCLES - 1) begin n_fail++; $display("FAIL flush_len: %0d cycles without ready, required %0d", n, FLUSH_CYCLES - 1); end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    wait_resp(0, 200, c);
    n_checks++;
    if (c < 0 || bus.resp0_rd !== 32'd2) begin n_fail++; $display("FAIL first_op: cyc=%0d rd=%h, required rd=2", c, bus.resp0_rd); end
  endtask

  task automatic test_single_add();
    int c, s0, r0;
    s0 = n_start; r0 = r1_seen; lat = 32;
    @(negedge clk);
    {bus.req0_rs1, bus.req0_rs2, bus.req0_func3, bus.req0_func7, bus.req0_imm_t} = mk(32'd5, 32'd7, 3'd0, 7'd0);
    bus.req0_valid = 1'b1; bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready: ready0=%b, required 1", bus.req0_ready); end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.alu_start !== 1'b1 || bus.alu_rs1 !== 32'd5 || bus.alu_rs2 !== 32'd7) begin
      n_fail++; $display("FAIL add_start: start=%b rs1=%h rs2=%h, required 1/5/7", bus.alu_start, bus.alu_rs1, bus.alu_rs2);
    end
    wait_resp(0, 200, c);
    n_checks++;
    if (c != lat + 1) begin n_fail++; $display("FAIL add_latency: %0d cycles start to resp, required %0d", c, lat + 1); end
    n_checks++;
    if (bus.resp0_rd !== 32'd12 || bus.resp0_err !== 1'b0) begin n_fail++; $display("FAIL add_rd: rd=%h err=%b, required 0000000c/0", bus.resp0_rd, bus.resp0_err); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_start - s0 != 1 || r1_seen != r0) begin n_fail++; $display("FAIL add_pulse: starts=%0d resp1=%0d, required 1/0", n_start - s0, r1_seen - r0); end
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
  endtask

  task automatic test_contention();
    int g0, l0;
    int eg[6] = '{0, 1, 0, 1, 0, 1};
    do_reset();
    lat = 32;
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(32'd10, 32'd3, 3'd0, 7'h20));
      q1.push_back(mk(32'hF0, 32'h0F, 3'd4, 7'd0));
    end
    g0 = glog.size(); l0 = rlog_rd.size();
    run_ops(0, 2000);
    n_checks++;
    if (glog.size() - g0 != 6) begin n_fail++; $display("FAIL cont_grants: %0d grants, required 6", glog.size() - g0); end
    for (int i = 0; i < 6 && g0 + i < glog.size(); i++) begin
      n_checks++;
      if (glog[g0 + i].gnt != eg[i]) begin n_fail++; $display("FAIL cont_order[%0d]: granted %0d, required %0d", i, glog[g0 + i].gnt, eg[i]); end
    end
    for (int i = 0; i < 6 && l0 + i < rlog_rd.size(); i++) begin
      n_checks++;
      if (rlog_own[l0 + i] != eg[i] || rlog_rd[l0 + i] !== (eg[i] == 0 ? 32'd7 : 32'hFF)) begin
        n_fail++; $display("FAIL cont_result[%0d]: owner=%0d rd=%h", i, rlog_own[l0 + i], rlog_rd[l0 + i]);
      end
    end
  endtask

  task automatic test_back_pressure();
    int c;
    @(negedge clk);
    {bus.req1_rs1, bus.req1_rs2, bus.req1_func3, bus.req1_func7, bus.req1_imm_t} = mk(32'hA0, 32'h05, 3'd6, 7'd0);
    bus.req1_valid = 1'b1; bus.resp1_ready = 1'b0; bus.resp0_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1: ready1=%b, required 1", bus.req1_ready); end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    {bus.req0_rs1, bus.req0_rs2, bus.req0_func3, bus.req0_func7, bus.req0_imm_t} = mk(32'd1, 32'd2, 3'd0, 7'd0);
    bus.req0_valid = 1'b1;
    wait_resp(1, 200, c);
    n_checks++;
    if (c < 0) begin n_fail++; $display("FAIL bp_resp: no resp1_valid within 200 cycles"); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.resp1_valid !== 1'b1 || bus.resp1_rd !== 32'hA5 || bus.req0_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: valid1=%b rd1=%h ready0=%b, required 1/a5/0", i, bus.resp1_valid, bus.resp1_rd, bus.req0_ready);
      end
    end
    @(negedge clk);
    bus.resp1_ready = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.resp1_valid !== 1'b0 || bus.req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: valid1=%b ready0=%b, required 0/1", bus.resp1_valid, bus.req0_ready);
    end
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.resp1_ready = 1'b0;
    wait_resp(0, 200, c);
    n_checks++;
    if (c < 0 || bus.resp0_rd !== 32'd3) begin n_fail++; $display("FAIL bp_after: cyc=%0d rd0=%h, required 3", c, bus.resp0_rd); end
    @(negedge clk);
    bus.resp0_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int c, n;
    hang = 1;
    @(negedge clk);
    {bus.req0_rs1, bus.req0_rs2, bus.req0_func3, bus.req0_func7, bus.req0_imm_t} = mk(32'hFF, 32'h0F, 3'd7, 7'd0);
    bus.req0_valid = 1'b1; bus.resp0_ready = 1'b0;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.alu_start !== 1'b1) begin n_fail++; $display("FAIL to_start: start=%b, required 1", bus.alu_start); end
    wait_resp(0, 300, c);
    n_checks++;
    if (c != TIMEOUT_CYCLES + 1) begin n_fail++; $display("FAIL to_latency: %0d cycles, required %0d", c, TIMEOUT_CYCLES + 1); end
    n_checks++;
    if (bus.resp0_err !== 1'b1 || bus.resp0_rd !== 32'd0) begin n_fail++; $display("FAIL to_err: err=%b rd=%h, required 1/0", bus.resp0_err, bus.resp0_rd); end
    @(negedge clk);
    bus.resp0_ready = 1'b1;
    {bus.req0_rs1, bus.req0_rs2, bus.req0_func3, bus.req0_func7, bus.req0_imm_t} = mk(32'd4, 32'd4, 3'd0, 7'd0);
    bus.req0_valid = 1'b1;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      #1;
      if (bus.req0_ready) break;
      n++;
    end
    hang = 0;
    n_checks++;
    if (n != FLUSH_CYCLES) begin n_fail++; $display("FAIL to_flush: %0d cycles without ready, required %0d", n, FLUSH_CYCLES); end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    wait_resp(0, 200, c);
    n_checks++;
    if (c < 0 || bus.resp0_rd !== 32'd8 || bus.resp0_err !== 1'b0) begin n_fail++; $display("FAIL to_recover: rd=%h err=%b, required 8/0", bus.resp0_rd, bus.resp0_err); end
    @(negedge clk);
    bus.resp0_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait(input bit hung, input int expect_n);
    int n, c, seen;
    hang = hung; lat = 40;
    @(negedge clk);
    {bus.req1_rs1, bus.req1_rs2, bus.req1_func3, bus.req1_func7, bus.req1_imm_t} = mk(32'h3, 32'h5, 3'd4, 7'd0);
    bus.req1_valid = 1'b1; bus.resp1_ready = 1'b1; bus.resp0_ready = 1'b1;
    @(negedge clk);
    bus.req1_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    {bus.req0_rs1, bus.req0_rs2, bus.req0_func3, bus.req0_func7, bus.req0_imm_t} = mk(32'd9, 32'd1, 3'd0, 7'd0);
    bus.req0_valid = 1'b1;
    #1;
    n_checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid, bus.resp0_err, bus.resp1_err, bus.alu_start} !== 7'd0
        || alu_now() !== '0 || {bus.resp0_rd, bus.resp1_rd} !== 64'd0) begin
      n_fail++; $display("FAIL rst_mid_zero: outputs not cleared, alu=%h rd=%h/%h", alu_now(), bus.resp0_rd, bus.resp1_rd);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0; seen = 0;
    while (n < 200) begin
      @(negedge clk);
      #1;
      if (bus.resp0_valid | bus.resp1_valid) seen++;
      if (bus.req0_ready) break;
      n++;
    end
    hang = 0; lat = 32;
    n_checks++;
    if (n != expect_n || seen != 0) begin n_fail++; $display("FAIL rst_mid_flush: %0d cycles no ready, %0d resp, required %0d/0", n, seen, expect_n); end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    wait_resp(0, 200, c);
    n_checks++;
    if (c < 0 || bus.resp0_rd !== 32'd10) begin n_fail++; $display("FAIL rst_mid_after: rd0=%h, required 0000000a", bus.resp0_rd); end
    @(negedge clk);
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
  endtask

  task automatic test_operand_stability();
    int c, u0;
    u0 = unstable; lat = 63;
    @(negedge clk);
    {bus.req0_rs1, bus.req0_rs2, bus.req0_func3, bus.req0_func7, bus.req0_imm_t} = mk(32'h80000000, 32'd4, 3'd5, 7'h20);
    bus.req0_valid = 1'b1; bus.resp0_ready = 1'b1;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    wait_resp(0, 200, c);
    n_checks++;
    if (c != 64 || bus.resp0_rd !== 32'hF8000000) begin n_fail++; $display("FAIL sra: cyc=%0d rd=%h, required 64/f8000000", c, bus.resp0_rd); end
    n_checks++;
    if (unstable != u0) begin n_fail++; $display("FAIL stability: %0d unstable cycles, required 0", unstable - u0); end
    @(negedge clk);
    bus.resp0_ready = 1'b0; lat = 32;
  endtask

  task automatic test_random();
    int g0, u0;
    op_t o;
    g0 = glog.size(); u0 = unstable; rand_lat = 1;
    for (int i = 0; i < 24; i++) begin
      o = {$urandom, $urandom, 3'($urandom_range(0, 7)), ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, 1'($urandom_range(0, 1))};
      if (i % 2 == 0) q0.push_back(o);
      else q1.push_back(o);
    end
    run_ops(1, 20000);
    rand_lat = 0;
    for (int i = g0; i < glog.size(); i++) begin
      n_checks++;
      if (glog[i].gnt != glog[i].exp) begin
        n_fail++; $display("FAIL rr_grant[%0d]: valids=%0d%0d granted %0d, required %0d", i, glog[i].v0, glog[i].v1, glog[i].gnt, glog[i].exp);
      end
    end
    n_checks++;
    if (unstable != u0) begin n_fail++; $display("FAIL rand_stability: %0d unstable cycles, required 0", unstable - u0); end
  endtask

  initial begin
    {bus.req0_valid, bus.req0_rs1, bus.req0_rs2, bus.req0_func3, bus.req0_func7, bus.req0_imm_t} = '0;
    {bus.req1_valid, bus.req1_rs1, bus.req1_rs2, bus.req1_func3, bus.req1_func7, bus.req1_imm_t} = '0;
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
    bus.alu_done = 1'b0; bus.alu_rd = '0;
    test_reset();
    test_single_add();
    test_contention();
    test_back_pressure();
    test_timeout();
    test_reset_mid_wait(1'b1, FLUSH_CYCLES - 1);
    test_reset_mid_wait(1'b0, 29);
    test_operand_stability();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
